legv8_multicycle_ctrl: RTL and testbench
========================================

# legv8_multicycle_ctrl

Multi-cycle sequencer for the LEGv8 datapath. It replaces single-cycle control with an FSM that walks each instruction through the FETCH, DECODE, EXEC, MEM and WB phases. It handshakes with instruction and data memories that have variable latency, and it holds the architectural N/Z/V/C flag register. It sits beside the register file, ALU and memories and drives their enables, muxes and ALU operation.

## Interface
Parameters:
- RETIRE_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  11  instruction[31:21] from the datapath IR, valid from DECODE onward
- imem_ack  in  1  instruction word valid this cycle
- dmem_ack  in  1  data access complete this cycle
- alu_zero, alu_negative, alu_overflow, alu_carry  in  1 each  current ALU result flags
- imem_req  out  1  fetch request
- ir_write  out  1  latch instruction into IR
- pc_write  out  1  update PC
- pc_src  out  2  00 PC+4, 01 PC+branch offset, 10 register (BR)
- alu_op  out  3  000 pass B, 010 add, 011 sub
- alu_src_imm  out  1  ALU B operand is the immediate
- flag_write  out  1  flags register updated this cycle
- reg_write  out  1  register-file write enable
- rd_link  out  1  write destination is X30, not instruction[4:0]
- wb_src  out  2  00 ALU, 01 dmem, 10 PC+4
- dmem_read_en, dmem_write_en  out  1 each  data memory request
- flags_q  out  4  {N,Z,V,C} register
- trap  out  1  sticky illegal-opcode indicator
- retired  out  RETIRE_W  count of completed instructions

## Operation
- Decode, matching patterns in this priority order:
  - B 000101?????
  - BL 100101?????
  - B.LT 01010100???
  - CBZ 10110100???
  - ADDS 10101011000
  - SUBS 11101011000
  - BR 11010110000
  - ADDI 1001000100?
  - LDUR 11111000010
  - STUR 11111000000
  - anything else is ILLEGAL
- The opcode class is latched in DECODE and held until the next DECODE.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1.
  - On imem_ack, assert ir_write and go to DECODE; otherwise stay.
- DECODE:
  - One cycle; latch the class.
  - ILLEGAL goes to HALT; every other class goes to EXEC.
- EXEC:
  - ADDS/SUBS: alu_op 010/011, flag_write=1, then WB.
  - ADDI: alu_op 010, alu_src_imm=1, then WB.
  - LDUR/STUR: alu_op 010, alu_src_imm=1, then MEM.
  - CBZ: alu_op 000. pc_write=1 with pc_src=01 if alu_zero, else 00. Then FETCH.
  - B: pc_write=1, pc_src=01, then FETCH.
  - B.LT: pc_write=1. pc_src=01 if flags_q.N^flags_q.V, else 00. Uses the registered flags only. Then FETCH.
  - BR: pc_write=1, pc_src=10, then FETCH.
  - BL: go to WB.
- MEM:
  - Assert dmem_read_en (LDUR) or dmem_write_en (STUR) until the dmem_ack cycle, inclusive.
  - LDUR then goes to WB.
  - STUR asserts pc_write with pc_src=00 in the ack cycle, then goes to FETCH.
- WB:
  - reg_write=1, pc_write=1, then FETCH.
  - wb_src: ALU for ADDS/SUBS/ADDI, dmem for LDUR, PC+4 for BL.
  - rd_link=1 only for BL.
  - pc_src=01 for BL, 00 otherwise.
- HALT: all enables 0, trap=1; exit only via reset.
- Flags:
  - flags_q <= {alu_negative, alu_zero, alu_overflow, alu_carry} on flag_write.
  - Otherwise flags_q holds.
- retired increments on every pc_write cycle and wraps modulo 2^RETIRE_W.

## Timing
- Reset (reset=0), asynchronous:
  - state=FETCH, flags_q=0, retired=0, trap=0.
  - Every other output is 0, except that imem_req is 1 combinationally while in FETCH.
  - After reset deasserts, the first imem_req is in the first clocked cycle.
- Outputs are Moore-style from state and the latched class, except the following, which are combinational in the acknowledging or evaluating cycle:
  - ir_write (from imem_ack)
  - the MEM pc_write (from dmem_ack)
  - the CBZ pc_src (from alu_zero)
- Latency in cycles with zero-wait memories (ack in the first request cycle):
  - B, B.LT, CBZ, BR: 3
  - ADDS, SUBS, ADDI, BL: 4
  - STUR: 4
  - LDUR: 5
- Each wait cycle adds 1.
- A flag write in one instruction's EXEC is visible to a B.LT in the next instruction.
- Reset during MEM drops dmem_*_en immediately and abandons the access.
- Exactly one pc_write per instruction.
- reg_write and dmem_write_en are never both 1.

## Structure
- Package legv8_ctrl_pkg:
  - state_e
  - op_class_e
  - ALUOp constants (ALU_PASSB, ALU_ADD, ALU_SUB)
  - pc_src and wb_src constants
  - opcode pattern constants
- Sub-module legv8_opcode_class: a combinational casez decoder from opcode to op_class_e.
- The FSM, the flags register and the counter all live in the top module.

## Test plan
- ADDI, zero-wait imem: imem_ack=1 in FETCH → FETCH, DECODE, EXEC, WB. reg_write=1 and pc_write=1 with pc_src=00 in WB. retired 0→1.
- SUBS with ALU N=1, V=0, followed by B.LT → flags_q=1000 after SUBS EXEC. B.LT EXEC has pc_src=01. Repeating with N=1, V=1 gives pc_src=00.
- LDUR with dmem_ack delayed 3 cycles → dmem_read_en high for 4 consecutive cycles. WB has wb_src=01, reg_write=1. Total latency 8.
- BL → WB has rd_link=1, wb_src=10, pc_src=01. STUR with dmem_ack=1 → no reg_write, pc_write in the MEM cycle.
- Opcode 11'h000 → HALT, trap=1, no further imem_req. Asserting reset=0 clears trap and returns to FETCH.
- Reset asserted mid-MEM of STUR → dmem_write_en drops the same cycle. flags_q and retired read 0.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle sequencer.
package legv8_ctrl_pkg;

  // Sequencer phases
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Instruction classes recognised by the decoder
  typedef enum logic [3:0] {
    CLS_B       = 4'd0,
    CLS_BL      = 4'd1,
    CLS_BLT     = 4'd2,
    CLS_CBZ     = 4'd3,
    CLS_ADDS    = 4'd4,
    CLS_SUBS    = 4'd5,
    CLS_BR      = 4'd6,
    CLS_ADDI    = 4'd7,
    CLS_LDUR    = 4'd8,
    CLS_STUR    = 4'd9,
    CLS_ILLEGAL = 4'd10
  } op_class_e;

  // ALU operation select
  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;

  // PC source select
  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_REG    = 2'b10;

  // Write-back source select
  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_DMEM = 2'b01;
  localparam logic [1:0] WB_SRC_PC4  = 2'b10;

  // Opcode patterns as value/mask pairs (mask bit 1 = bit must match)
  localparam logic [10:0] OPC_B_VAL    = 11'b00010100000;
  localparam logic [10:0] OPC_B_MSK    = 11'b11111100000;
  localparam logic [10:0] OPC_BL_VAL   = 11'b10010100000;
  localparam logic [10:0] OPC_BL_MSK   = 11'b11111100000;
  localparam logic [10:0] OPC_BLT_VAL  = 11'b01010100000;
  localparam logic [10:0] OPC_BLT_MSK  = 11'b11111111000;
  localparam logic [10:0] OPC_CBZ_VAL  = 11'b10110100000;
  localparam logic [10:0] OPC_CBZ_MSK  = 11'b11111111000;
  localparam logic [10:0] OPC_ADDS_VAL = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS_VAL = 11'b11101011000;
  localparam logic [10:0] OPC_BR_VAL   = 11'b11010110000;
  localparam logic [10:0] OPC_ADDI_VAL = 11'b10010001000;
  localparam logic [10:0] OPC_ADDI_MSK = 11'b11111111110;
  localparam logic [10:0] OPC_LDUR_VAL = 11'b11111000010;
  localparam logic [10:0] OPC_STUR_VAL = 11'b11111000000;
  localparam logic [10:0] OPC_FULL_MSK = 11'b11111111111;

  // True when op equals val on every bit selected by msk
  function automatic logic opc_match(input logic [10:0] op,
                                     input logic [10:0] val,
                                     input logic [10:0] msk);
    return (((op ^ val) & msk) == 11'd0);
  endfunction

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational opcode classifier; earlier patterns take priority.
module legv8_opcode_class
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_e   w_class
);

  // Priority match of the opcode against the known instruction patterns
  always_comb begin
    w_class = CLS_ILLEGAL;
    casez (1'b1)
      opc_match(opcode, OPC_B_VAL,    OPC_B_MSK):    w_class = CLS_B;
      opc_match(opcode, OPC_BL_VAL,   OPC_BL_MSK):   w_class = CLS_BL;
      opc_match(opcode, OPC_BLT_VAL,  OPC_BLT_MSK):  w_class = CLS_BLT;
      opc_match(opcode, OPC_CBZ_VAL,  OPC_CBZ_MSK):  w_class = CLS_CBZ;
      opc_match(opcode, OPC_ADDS_VAL, OPC_FULL_MSK): w_class = CLS_ADDS;
      opc_match(opcode, OPC_SUBS_VAL, OPC_FULL_MSK): w_class = CLS_SUBS;
      opc_match(opcode, OPC_BR_VAL,   OPC_FULL_MSK): w_class = CLS_BR;
      opc_match(opcode, OPC_ADDI_VAL, OPC_ADDI_MSK): w_class = CLS_ADDI;
      opc_match(opcode, OPC_LDUR_VAL, OPC_FULL_MSK): w_class = CLS_LDUR;
      opc_match(opcode, OPC_STUR_VAL, OPC_FULL_MSK): w_class = CLS_STUR;
      default:                                       w_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multi-cycle sequencer: FSM, architectural flags and retire counter.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         opcode,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  input  logic                alu_zero,
  input  logic                alu_negative,
  input  logic                alu_overflow,
  input  logic                alu_carry,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [2:0]          alu_op,
  output logic                alu_src_imm,
  output logic                flag_write,
  output logic                reg_write,
  output logic                rd_link,
  output logic [1:0]          wb_src,
  output logic                dmem_read_en,
  output logic                dmem_write_en,
  output logic [3:0]          flags_q,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [2:0] ST_FETCH  = S_FETCH;
  localparam logic [2:0] ST_DECODE = S_DECODE;
  localparam logic [2:0] ST_EXEC   = S_EXEC;
  localparam logic [2:0] ST_MEM    = S_MEM;
  localparam logic [2:0] ST_WB     = S_WB;
  localparam logic [2:0] ST_HALT   = S_HALT;

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  op_class_e           r_class;
  op_class_e           w_dec_class;
  logic [3:0]          r_flags;
  logic [RETIRE_W-1:0] r_retired;
  logic                r_trap;

  legv8_opcode_class u_class (
    .opcode  (opcode),
    .w_class (w_dec_class)
  );

  assign flags_q = r_flags;
  assign retired = r_retired;
  assign trap    = r_trap;

  // Next-state selection; memory phases wait for their acknowledge
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (imem_ack) w_next_state = ST_DECODE;
        else          w_next_state = ST_FETCH;
      end
      ST_DECODE: begin
        if (w_dec_class == CLS_ILLEGAL) w_next_state = ST_HALT;
        else                            w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        case (r_class)
          CLS_ADDS, CLS_SUBS, CLS_ADDI, CLS_BL: w_next_state = ST_WB;
          CLS_LDUR, CLS_STUR:                   w_next_state = ST_MEM;
          default:                              w_next_state = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (!dmem_ack)                  w_next_state = ST_MEM;
        else if (r_class == CLS_LDUR)   w_next_state = ST_WB;
        else                            w_next_state = ST_FETCH;
      end
      ST_WB:   w_next_state = ST_FETCH;
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_FETCH;
    endcase
  end

  // Datapath controls from state and latched class (acks and alu_zero pass through)
  always_comb begin
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_SRC_PLUS4;
    alu_op        = ALU_PASSB;
    alu_src_imm   = 1'b0;
    flag_write    = 1'b0;
    reg_write     = 1'b0;
    rd_link       = 1'b0;
    wb_src        = WB_SRC_ALU;
    dmem_read_en  = 1'b0;
    dmem_write_en = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
      end
      ST_EXEC: begin
        case (r_class)
          CLS_ADDS: begin alu_op = ALU_ADD; flag_write = 1'b1; end
          CLS_SUBS: begin alu_op = ALU_SUB; flag_write = 1'b1; end
          CLS_ADDI, CLS_LDUR, CLS_STUR: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
          end
          CLS_CBZ: begin
            pc_write = 1'b1;
            pc_src   = alu_zero ? PC_SRC_BRANCH : PC_SRC_PLUS4;
          end
          CLS_B: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_BRANCH;
          end
          CLS_BLT: begin
            pc_write = 1'b1;
            // Signed less-than from the registered flags: N != V
            pc_src   = (r_flags[3] ^ r_flags[1]) ? PC_SRC_BRANCH : PC_SRC_PLUS4;
          end
          CLS_BR: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_REG;
          end
          default: alu_op = ALU_PASSB;
        endcase
      end
      ST_MEM: begin
        if (r_class == CLS_LDUR) begin
          dmem_read_en = 1'b1;
        end else if (r_class == CLS_STUR) begin
          dmem_write_en = 1'b1;
          pc_write      = dmem_ack;
        end else begin
          dmem_read_en = 1'b0;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (r_class == CLS_BL) begin
          rd_link = 1'b1;
          wb_src  = WB_SRC_PC4;
          pc_src  = PC_SRC_BRANCH;
        end else if (r_class == CLS_LDUR) begin
          wb_src = WB_SRC_DMEM;
        end else begin
          wb_src = WB_SRC_ALU;
        end
      end
      default: imem_req = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_FETCH;
    else        r_state <= w_next_state;
  end

  // Instruction class captured in DECODE and held until the next DECODE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_class <= CLS_ILLEGAL;
    else if (r_state == ST_DECODE) r_class <= w_dec_class;
    else                          r_class <= r_class;
  end

  // Architectural {N,Z,V,C} flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_flags <= 4'd0;
    else if (flag_write) r_flags <= {alu_negative, alu_zero, alu_overflow, alu_carry};
    else                 r_flags <= r_flags;
  end

  // Retired-instruction counter: one pc_write per instruction, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_retired <= '0;
    else if (pc_write) r_retired <= r_retired + RETIRE_W'(1);
    else               r_retired <= r_retired;
  end

  // Sticky illegal-opcode indicator, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       r_trap <= 1'b0;
    else if (w_next_state == ST_HALT) r_trap <= 1'b1;
    else                              r_trap <= r_trap;
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for legv8_multicycle_ctrl: each issued instruction pushes
// its expected retire-cycle response; a monitor checks every pc_write cycle.
module tb_legv8_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [10:0] opcode;
  logic        imem_ack, dmem_ack;
  logic        alu_zero, alu_negative, alu_overflow, alu_carry;
  logic        imem_req, ir_write, pc_write, alu_src_imm, flag_write;
  logic        reg_write, rd_link, dmem_read_en, dmem_write_en, trap;
  logic [1:0]  pc_src, wb_src;
  logic [2:0]  alu_op;
  logic [3:0]  flags_q;
  logic [31:0] retired;

  legv8_multicycle_ctrl #(.RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .flag_write(flag_write), .reg_write(reg_write), .rd_link(rd_link),
    .wb_src(wb_src), .dmem_read_en(dmem_read_en), .dmem_write_en(dmem_write_en),
    .flags_q(flags_q), .trap(trap), .retired(retired)
  );

  typedef struct {
    string      nm;
    int         lat;
    logic [1:0] psrc;
    logic [1:0] wsrc;
    logic       rl;
    logic       rw;
    int         rdc;
    int         wrc;
    logic [3:0] fl;
    int         ret;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_done   = 0;
  int   cyc      = 0;
  int   start    = 0;
  int   rd_cyc   = 0;
  int   wr_cyc   = 0;
  int   conflict = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: accumulate per-instruction activity and check at every pc_write
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      rd_cyc = 0; wr_cyc = 0; conflict = 0;
    end else begin
      if (dmem_read_en) rd_cyc++;
      if (dmem_write_en) wr_cyc++;
      if (reg_write && dmem_write_en) conflict++;
      if (pc_write) begin
        if (sb.size() == 0) begin
          chk("unexpected_pc_write", 1, 0);
        end else begin
          e = sb.pop_front();
          chk({e.nm, " latency"},   cyc - start + 1, e.lat);
          chk({e.nm, " pc_src"},    pc_src,    e.psrc);
          chk({e.nm, " wb_src"},    wb_src,    e.wsrc);
          chk({e.nm, " rd_link"},   rd_link,   e.rl);
          chk({e.nm, " reg_write"}, reg_write, e.rw);
          chk({e.nm, " rd_cycles"}, rd_cyc,    e.rdc);
          chk({e.nm, " wr_cycles"}, wr_cyc,    e.wrc);
          chk({e.nm, " flags_q"},   flags_q,   e.fl);
          chk({e.nm, " retired"},   retired,   e.ret);
          chk({e.nm, " rw_and_wr"}, conflict,  0);
        end
        n_done++;
        rd_cyc = 0; wr_cyc = 0; conflict = 0;
      end
    end
  end

  // Issue one instruction from FETCH, responding to memory requests until it retires
  task automatic run_instr(input string nm, input logic [10:0] op, input int iwait,
                           input int dwait, input logic [3:0] nzvc, input int lat,
                           input logic [1:0] psrc, input logic [1:0] wsrc,
                           input logic rl, input logic rw, input int rdc,
                           input int wrc, input logic [3:0] fl, input int ret);
    int   ic, dc, tgt, t;
    exp_t e;
    t = 0;
    while (!imem_req && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk({nm, " fetch_req"}, imem_req, 1);
    opcode = op;
    {alu_negative, alu_zero, alu_overflow, alu_carry} = nzvc;
    e.nm = nm; e.lat = lat; e.psrc = psrc; e.wsrc = wsrc; e.rl = rl; e.rw = rw;
    e.rdc = rdc; e.wrc = wrc; e.fl = fl; e.ret = ret;
    sb.push_back(e);
    start = cyc;
    tgt = n_done + 1;
    ic = 0; dc = 0; t = 0;
    while (n_done < tgt && t < 60) begin
      imem_ack = imem_req && (ic >= iwait);
      if (imem_req) ic++;
      dmem_ack = (dmem_read_en || dmem_write_en) && (dc >= dwait);
      if (dmem_read_en || dmem_write_en) dc++;
      @(posedge clk); #1; t++;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (n_done < tgt) chk({nm, " retire_timeout"}, 0, 1);
  endtask

  initial begin
    int req_seen;
    reset = 1'b0; opcode = 11'd0; imem_ack = 1'b0; dmem_ack = 1'b0;
    {alu_negative, alu_zero, alu_overflow, alu_carry} = 4'b0000;
    #12;
    chk("rst imem_req",  imem_req, 1);
    chk("rst ir_write",  ir_write, 0);
    chk("rst pc_write",  pc_write, 0);
    chk("rst reg_write", reg_write, 0);
    chk("rst dmem_en",   {dmem_read_en, dmem_write_en}, 0);
    chk("rst flags_q",   flags_q, 0);
    chk("rst retired",   retired, 0);
    chk("rst trap",      trap, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    //         name     opcode          iw dw nzvc     lat ps     ws     rl rw rd wr fl       ret
    run_instr("ADDI",  11'b10010001000, 0, 0, 4'b0000, 4, 2'b00, 2'b00, 0, 1, 0, 0, 4'b0000, 0);
    run_instr("SUBS",  11'b11101011000, 0, 0, 4'b1000, 4, 2'b00, 2'b00, 0, 1, 0, 0, 4'b1000, 1);
    run_instr("BLT_t", 11'b01010100000, 0, 0, 4'b0000, 3, 2'b01, 2'b00, 0, 0, 0, 0, 4'b1000, 2);
    run_instr("ADDS",  11'b10101011000, 0, 0, 4'b1010, 4, 2'b00, 2'b00, 0, 1, 0, 0, 4'b1010, 3);
    run_instr("BLT_n", 11'b01010100011, 0, 0, 4'b0000, 3, 2'b00, 2'b00, 0, 0, 0, 0, 4'b1010, 4);
    run_instr("LDUR",  11'b11111000010, 0, 3, 4'b0000, 8, 2'b00, 2'b01, 0, 1, 4, 0, 4'b1010, 5);
    run_instr("BL",    11'b10010111111, 0, 0, 4'b0000, 4, 2'b01, 2'b10, 1, 1, 0, 0, 4'b1010, 6);
    run_instr("STUR",  11'b11111000000, 0, 0, 4'b0000, 4, 2'b00, 2'b00, 0, 0, 0, 1, 4'b1010, 7);
    run_instr("CBZ_t", 11'b10110100101, 0, 0, 4'b0100, 3, 2'b01, 2'b00, 0, 0, 0, 0, 4'b1010, 8);
    run_instr("CBZ_n", 11'b10110100101, 2, 0, 4'b0000, 5, 2'b00, 2'b00, 0, 0, 0, 0, 4'b1010, 9);
    run_instr("BR",    11'b11010110000, 0, 0, 4'b0000, 3, 2'b10, 2'b00, 0, 0, 0, 0, 4'b1010, 10);
    run_instr("B",     11'b00010111111, 0, 0, 4'b0000, 3, 2'b01, 2'b00, 0, 0, 0, 0, 4'b1010, 11);
    run_instr("ADDI1", 11'b10010001001, 1, 0, 4'b0000, 5, 2'b00, 2'b00, 0, 1, 0, 0, 4'b1010, 12);
    run_instr("STURw", 11'b11111000000, 0, 2, 4'b0000, 6, 2'b00, 2'b00, 0, 0, 0, 3, 4'b1010, 13);

    // Illegal opcode: HALT, sticky trap, no more fetches
    chk("pre_illegal trap", trap, 0);
    opcode = 11'h000;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    chk("halt trap", trap, 1);
    req_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req || pc_write) req_seen++;
      @(posedge clk); #1;
    end
    chk("halt no_req", req_seen, 0);
    chk("halt retired", retired, 14);
    reset = 1'b0;
    #1;
    chk("halt_rst trap", trap, 0);
    chk("halt_rst imem_req", imem_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset during a stalled STUR access
    run_instr("ADDS2", 11'b10101011000, 0, 0, 4'b0101, 4, 2'b00, 2'b00, 0, 1, 0, 0, 4'b0101, 0);
    opcode = 11'b11111000000;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mem dmem_write_en", dmem_write_en, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst dmem_write_en", dmem_write_en, 0);
    chk("mid_rst flags_q", flags_q, 0);
    chk("mid_rst retired", retired, 0);
    chk("mid_rst imem_req", imem_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
